// File: rtl/seq_divider_8bits_if.sv
// Request/response bundle for the sequential 8-bit divider.
// The requester drives start and the operands; the divider returns the result and status.
interface seq_divider_8bits_if;
  logic       start;
  logic [7:0] i;
  logic [7:0] h;
  logic [7:0] q;
  logic [7:0] r;
  logic       busy;
  logic       done;
  logic       dbz;

  modport master (
    output start, i, h,
    input  q, r, busy, done, dbz
  );

  modport slave (
    input  start, i, h,
    output q, r, busy, done, dbz
  );
endinterface

// File: rtl/seq_divider_8bits.sv
// Unsigned 8-bit restoring divider that produces one quotient bit per clock.
// The result is loaded into q/r only when the operation completes, so an
// aborted run never exposes a partial quotient.
//
// state | meaning
// IDLE  | waiting for start; the last result is held on q/r/dbz
// RUN   | eight shift/trial-subtract iterations
// DONE  | one-cycle completion pulse; start here begins a new operation at once
module seq_divider_8bits (
  input  logic                clk,
  input  logic                rst,
  seq_divider_8bits_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [8:0]  a_q, a_d;     // partial remainder; 9 bits so a shifted-out MSB survives when D >= 128
  logic [7:0]  qw_q, qw_d;   // working quotient, shifted in from the right
  logic [7:0]  d_q, d_d;     // divisor latched when the operation is accepted
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  q_q, q_d;
  logic [7:0]  r_q, r_d;
  logic        dbz_q, dbz_d;

  logic [8:0]  a_sh;
  logic [7:0]  qw_sh;
  logic [8:0]  trial;

  // Register the state, datapath and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= 9'd0;
      qw_q    <= 8'd0;
      d_q     <= 8'd0;
      cnt_q   <= 3'd0;
      q_q     <= 8'd0;
      r_q     <= 8'd0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      qw_q    <= qw_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dbz_q   <= dbz_d;
    end
  end

  // Next-state logic: accept, one restoring iteration per cycle, and completion.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    qw_d    = qw_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    dbz_d   = dbz_q;

    // Shift {A,Q} left by one, then subtract the divisor from the new A.
    // A clear bit 8 of the difference means no borrow, so the subtraction is kept.
    a_sh  = {a_q[7:0], qw_q[7]};
    qw_sh = {qw_q[6:0], 1'b0};
    trial = a_sh - {1'b0, d_q};

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          d_d   = bus.h;
          qw_d  = bus.i;
          a_d   = 9'd0;
          cnt_d = 3'd0;
          dbz_d = 1'b0;
          if (bus.h == 8'd0) begin
            // A zero divisor completes at once with a saturated quotient.
            state_d = S_DONE;
            q_d     = 8'hFF;
            r_d     = bus.i;
            dbz_d   = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_RUN: begin
        if (!trial[8]) begin
          a_d  = trial;
          qw_d = qw_sh | 8'd1;
        end else begin
          a_d  = a_sh;
          qw_d = qw_sh;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
          q_d     = qw_d;
          r_d     = a_d[7:0];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.q    = q_q;
  assign bus.r    = r_q;
  assign bus.dbz  = dbz_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_divider_8bits.sv
// Bench for seq_divider_8bits: directed timing and boundary cases plus random
// operands. Expected results come from integer division and go into a queue;
// a monitor pops one entry on every done pulse and compares.
module tb_seq_divider_8bits;

  logic clk;
  logic rst;
  seq_divider_8bits_if bus ();

  seq_divider_8bits dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] i;
    logic [7:0] h;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference result computed from the arithmetic definition of division.
  function automatic exp_t model(input logic [7:0] i, input logic [7:0] h);
    exp_t e;
    e.i = i;
    e.h = h;
    if (h == 8'd0) begin
      e.q = 8'hFF; e.r = i; e.dbz = 1'b1;
    end else begin
      e.q = i / h; e.r = i % h; e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Monitor: each done pulse consumes one expected result.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got q=%0d r=%0d with no pending request", bus.q, bus.r);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check($sformatf("q(%0d/%0d)", e.i, e.h), bus.q, e.q);
        check($sformatf("r(%0d/%0d)", e.i, e.h), bus.r, e.r);
        check($sformatf("dbz(%0d/%0d)", e.i, e.h), bus.dbz, e.dbz);
        if (e.h != 8'd0)
          check($sformatf("invariant(%0d/%0d)", e.i, e.h),
                ((32'(bus.q) * 32'(e.h) + 32'(bus.r)) == 32'(e.i)) && (bus.r < e.h), 1);
      end
    end
  end

  // Issue one request: start is sampled on the next rising edge, then the
  // operands are scrambled to show they were latched.
  task automatic do_start(input logic [7:0] i, input logic [7:0] h);
    bus.start = 1'b1;
    bus.i     = i;
    bus.h     = h;
    exp_q.push_back(model(i, h));
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.i     = 8'($urandom);
    bus.h     = 8'($urandom);
  endtask

  // Count cycles after the start edge until done is seen, with a bound.
  task automatic wait_done(output int cyc, output int busy_cyc);
    cyc = 0;
    busy_cyc = 0;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) break;
    end
    if (!bus.done) begin
      n_checks++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected done", cyc);
    end
  endtask

  int cyc, bcyc, snap;
  logic [7:0] ri, rh;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.i = 8'd0;
    bus.h = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_q", bus.q, 0);
    check("rst_r", bus.r, 0);
    check("rst_dbz", bus.dbz, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Basic timing: 8 busy cycles, done on the 9th.
    do_start(8'd200, 8'd7);
    wait_done(cyc, bcyc);
    check("basic_latency", cyc, 9);
    check("basic_busy_cycles", bcyc, 8);
    @(negedge clk);
    check("basic_done_one_cycle", bus.done, 0);

    // Boundaries.
    do_start(8'd255, 8'd1);   wait_done(cyc, bcyc);
    do_start(8'd255, 8'd255); wait_done(cyc, bcyc);
    do_start(8'd5, 8'd9);     wait_done(cyc, bcyc);
    do_start(8'd0, 8'd3);     wait_done(cyc, bcyc);
    do_start(8'd130, 8'd129); wait_done(cyc, bcyc);
    do_start(8'd255, 8'd128); wait_done(cyc, bcyc);
    @(negedge clk);

    // Divide by zero completes in the next cycle without busy.
    do_start(8'h80, 8'd0);
    wait_done(cyc, bcyc);
    check("dbz_latency", cyc, 1);
    check("dbz_busy_cycles", bcyc, 0);
    @(negedge clk);
    do_start(8'd9, 8'd3);
    wait_done(cyc, bcyc);
    check("after_dbz_latency", cyc, 9);

    // start during RUN is ignored.
    @(negedge clk);
    snap = done_cnt;
    do_start(8'd100, 8'd10);
    @(posedge clk); @(posedge clk);
    #1;
    bus.start = 1'b1; bus.i = 8'd50; bus.h = 8'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cyc = 3;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.done) break;
    end
    check("ignored_start_latency", cyc, 9);
    repeat (12) @(negedge clk);
    check("ignored_start_done_count", done_cnt - snap, 1);

    // Reset mid-operation aborts without a result.
    do_start(8'd200, 8'd7);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_q", bus.q, 0);
    check("abort_r", bus.r, 0);
    check("abort_dbz", bus.dbz, 0);
    snap = done_cnt;
    repeat (12) @(negedge clk);
    check("abort_no_done", done_cnt - snap, 0);

    // Back-to-back: new start held during the DONE cycle.
    do_start(8'd100, 8'd9);
    wait_done(cyc, bcyc);
    do_start(8'd77, 8'd6);
    @(negedge clk);
    check("b2b_done_drops", bus.done, 0);
    check("b2b_busy_rises", bus.busy, 1);
    cyc = 1;
    bcyc = 1;
    while (cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) bcyc++;
      if (bus.done) break;
    end
    check("b2b_latency", cyc, 9);
    check("b2b_busy_cycles", bcyc, 8);

    // Random operands, occasionally chained back-to-back.
    @(negedge clk);
    for (int n = 0; n < 1000; n++) begin
      ri = 8'($urandom);
      rh = 8'($urandom_range(1, 255));
      do_start(ri, rh);
      wait_done(cyc, bcyc);
      if ($urandom_range(0, 3) != 0) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
